alu_sequencer: RTL and testbench

//  Command-level controller for the 8-bit combinational ALU. Accepts one operation
//  per valid/ready handshake, drives the ALU select/operand inputs, and registers result
//  and flags into a response held until accepted. Sequences MUL as repeated ADD/SUB
//  on the same ALU, so the datapath needs no separate multiplier.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU select codes, command opcodes and sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] ALU_ADD       = 5'b00000;
  localparam logic [4:0] ALU_BITAND    = 5'b00001;
  localparam logic [4:0] ALU_INP_A     = 5'b00010;
  localparam logic [4:0] ALU_INP_B     = 5'b00011;
  localparam logic [4:0] ALU_SUB       = 5'b01100;
  localparam logic [4:0] ALU_INCREMENT = 5'b10100;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_PASSA = 3'd2;
  localparam logic [2:0] OP_PASSB = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_INC   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_CMP   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_MUL_ADD, ST_MUL_DEC, ST_RESP
  } state_e;

  // Single-cycle select; MUL only lands here when the sequence is disabled.
  function automatic logic [4:0] op_sel(input logic [2:0] op);
    case (op)
      OP_AND:   op_sel = ALU_BITAND;
      OP_PASSA: op_sel = ALU_INP_A;
      OP_PASSB: op_sel = ALU_INP_B;
      OP_SUB:   op_sel = ALU_SUB;
      OP_INC:   op_sel = ALU_INCREMENT;
      OP_CMP:   op_sel = ALU_SUB;
      default:  op_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command-level controller for an external 8-bit combinational ALU; MUL is
// sequenced as repeated ADD (acc += a) and SUB (cnt -= 1) on the same ALU.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 5,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_dout,
  input  logic              alu_carry,
  input  logic              alu_zero
);

  state_e              state_q;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q, acc_q, cnt_q;
  logic                sticky_q;
  logic                rsp_valid_q, rsp_carry_q, rsp_zero_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [4:0]          sel_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign alu_sel   = SEL_W'(sel_d);

  // ALU is parked on INP_A with zero operands whenever it is not doing work.
  always_comb begin
    sel_d = ALU_INP_A;
    alu_a = '0;
    alu_b = '0;
    case (state_q)
      ST_EXEC: begin
        sel_d = op_sel(op_q);
        alu_a = a_q;
        alu_b = b_q;
      end
      ST_MUL_ADD: if (cnt_q != '0) begin
        sel_d = ALU_ADD;
        alu_a = acc_q;
        alu_b = a_q;
      end
      ST_MUL_DEC: begin
        sel_d = ALU_SUB;
        alu_a = cnt_q;
        alu_b = DATA_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          a_q  <= cmd_a;
          b_q  <= cmd_b;
          if (MUL_EN != 0 && cmd_op == OP_MUL) begin
            acc_q    <= '0;
            cnt_q    <= cmd_b;
            sticky_q <= 1'b0;
            state_q  <= ST_MUL_ADD;
          end else begin
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // CMP reports operand a unchanged; only the flags come from the SUB.
          rsp_data_q  <= (op_q == OP_CMP) ? a_q : alu_dout;
          rsp_carry_q <= alu_carry;
          rsp_zero_q  <= alu_zero;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_MUL_ADD: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= acc_q;
            rsp_carry_q <= sticky_q;
            rsp_zero_q  <= (acc_q == '0) && !sticky_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            acc_q    <= alu_dout;
            sticky_q <= sticky_q | alu_carry;
            state_q  <= ST_MUL_DEC;
          end
        end
        ST_MUL_DEC: begin
          cnt_q   <= alu_dout;
          state_q <= ST_MUL_ADD;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 9-bit ALU model attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b, rsp_data, alu_a, alu_b, alu_dout;
  logic       rsp_carry, rsp_zero, busy, alu_carry, alu_zero;
  logic [4:0] alu_sel;
  logic [8:0] r9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(8), .SEL_W(5), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  always_comb begin
    r9 = '0;
    case (alu_sel)
      5'b00000: r9 = {1'b0, alu_a} + {1'b0, alu_b};
      5'b00001: r9 = {1'b0, alu_a & alu_b};
      5'b00010: r9 = {1'b0, alu_a};
      5'b00011: r9 = {1'b0, alu_b};
      5'b01100: r9 = {1'b0, alu_a} - {1'b0, alu_b};
      5'b10100: r9 = {1'b0, alu_a} + 9'd1;
      default:  r9 = '0;
    endcase
  end
  assign alu_dout  = r9[7:0];
  assign alu_carry = r9[8];
  assign alu_zero  = (r9 == 9'd0);

  // Issue one command, count busy cycles before rsp_valid, capture and accept response.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic c, output logic z,
                         output int cyc);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL timeout op=%0d: rsp_valid never rose", op);
    end
    d = rsp_data; c = rsp_carry; z = rsp_zero;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({rsp_data, rsp_carry, rsp_zero} !== 10'd0) begin errors++; $display("FAIL reset_rsp got %h/%b/%b want 0", rsp_data, rsp_carry, rsp_zero); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_hs busy=%b ready=%b want 0/1", busy, cmd_ready); end
    checks++; if (alu_sel !== 5'b00010 || alu_a !== 8'd0 || alu_b !== 8'd0) begin errors++; $display("FAIL reset_alu sel=%b a=%h b=%h want 00010/0/0", alu_sel, alu_a, alu_b); end
  endtask

  task automatic test_add();
    logic [7:0] d; logic c, z; int cyc;
    run_cmd(3'd0, 8'h80, 8'h80, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL add80 got %h/%b/%b want 00/1/0", d, c, z); end
    // one EXEC cycle between accept and rsp_valid = latency 2 from the accept cycle
    checks++; if (cyc !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", cyc); end
    run_cmd(3'd1, 8'hF0, 8'h3C, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h30, 1'b0, 1'b0}) begin errors++; $display("FAIL and got %h/%b/%b want 30/0/0", d, c, z); end
    run_cmd(3'd3, 8'h11, 8'h00, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h00, 1'b0, 1'b1}) begin errors++; $display("FAIL passb got %h/%b/%b want 00/0/1", d, c, z); end
    run_cmd(3'd5, 8'hFF, 8'h00, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL inc got %h/%b/%b want 00/1/0", d, c, z); end
    run_cmd(3'd2, 8'hA5, 8'h5A, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'hA5, 1'b0, 1'b0}) begin errors++; $display("FAIL passa got %h/%b/%b want a5/0/0", d, c, z); end
  endtask

  task automatic test_sub_cmp();
    logic [7:0] d; logic c, z; int cyc;
    run_cmd(3'd4, 8'h03, 8'h05, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'hFE, 1'b1, 1'b0}) begin errors++; $display("FAIL sub got %h/%b/%b want fe/1/0", d, c, z); end
    run_cmd(3'd7, 8'h05, 8'h05, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h05, 1'b0, 1'b1}) begin errors++; $display("FAIL cmp_eq got %h/%b/%b want 05/0/1", d, c, z); end
    run_cmd(3'd7, 8'h02, 8'h09, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h02, 1'b1, 1'b0}) begin errors++; $display("FAIL cmp_lt got %h/%b/%b want 02/1/0", d, c, z); end
  endtask

  task automatic test_mul();
    logic [7:0] d; logic c, z; int cyc;
    run_cmd(3'd6, 8'd7, 8'd9, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h3F, 1'b0, 1'b0}) begin errors++; $display("FAIL mul7x9 got %h/%b/%b want 3f/0/0", d, c, z); end
    checks++; if (cyc !== 19) begin errors++; $display("FAIL mul_cycles got %0d want 19", cyc); end
    run_cmd(3'd6, 8'd7, 8'd0, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h00, 1'b0, 1'b1} || cyc !== 1) begin errors++; $display("FAIL mul_b0 got %h/%b/%b cyc %0d want 00/0/1 cyc 1", d, c, z, cyc); end
    run_cmd(3'd6, 8'h20, 8'h10, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL mul_ovf got %h/%b/%b want 00/1/0", d, c, z); end
    run_cmd(3'd6, 8'd13, 8'd11, d, c, z, cyc);
    checks++; if ({d, c, z} !== {8'h8F, 1'b0, 1'b0}) begin errors++; $display("FAIL mul13x11 got %h/%b/%b want 8f/0/0", d, c, z); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    cmd_op = 3'd0; cmd_a = 8'h12; cmd_b = 8'h34; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'd4; cmd_a = 8'hFF; cmd_b = 8'h01;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_data !== 8'h46 || rsp_carry || rsp_zero || cmd_ready) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL no_overlap busy=%b ready=%b vld=%b want 0/1/0", busy, cmd_ready, rsp_valid); end
    cmd_valid = 1'b0;
    checks++; if (rsp_data !== 8'h46) begin errors++; $display("FAIL rsp_retain got %h want 46", rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2; logic c1, z1, c2, z2; int cyc;
    run_cmd(3'd0, 8'h01, 8'h02, d1, c1, z1, cyc);
    run_cmd(3'd4, 8'h10, 8'h10, d2, c2, z2, cyc);
    checks++; if ({d1, c1, z1, d2, c2, z2} !== {8'h03, 2'b00, 8'h00, 2'b01}) begin errors++; $display("FAIL b2b got %h/%b/%b %h/%b/%b want 03/0/0 00/0/1", d1, c1, z1, d2, c2, z2); end
  endtask

  task automatic test_reset_mid_mul();
    int bad = 0;
    cmd_op = 3'd6; cmd_a = 8'd1; cmd_b = 8'd200; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mul busy=%b ready=%b vld=%b want 0/1/0", busy, cmd_ready, rsp_valid); end
    checks++; if (alu_sel !== 5'b00010 || alu_a !== 8'd0 || alu_b !== 8'd0) begin errors++; $display("FAIL rst_mul_alu sel=%b a=%h b=%h want 00010/0/0", alu_sel, alu_a, alu_b); end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_rsp got %0d valid cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
